// File: rtl/btn_pkg.sv
// Shared types and helpers for the button reader: per-button FSM encoding
// and the counter-width function used to size every counter.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_PEND = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_PEND   = 2'd3
    } btn_state_e;

    // Bits needed to hold values 0..bound without wrapping.
    function automatic int cnt_width(input int bound);
        return (bound < 1) ? 1 : $clog2(bound + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer, polarity normalisation and the
// tick-driven debounce / hold FSM with registered level and strobes.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic pressed,
    output logic press_stb,
    output logic release_stb,
    output logic long_stb
);

    localparam int DB_W   = cnt_width(DEBOUNCE_TICKS);
    localparam int HOLD_W = cnt_width(LONG_TICKS);
    localparam logic              IDLE_LEVEL = ACTIVE_LOW;
    localparam logic [DB_W:0]     DB_LIMIT   = (DB_W + 1)'(DEBOUNCE_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(LONG_TICKS);

    logic              sync1_q, sync2_q;
    logic              sample;
    btn_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pressed_q, pressed_d;
    logic              press_stb_q, press_stb_d;
    logic              release_stb_q, release_stb_d;
    logic              long_stb_q, long_stb_d;
    logic [DB_W:0]     db_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q ^ ACTIVE_LOW;
    // One extra bit so the compare works even when the count sits at its bound.
    assign db_inc = {1'b0, db_q} + 1'b1;

    always_comb begin
        state_d       = state_q;
        db_d          = db_q;
        hold_d        = hold_q;
        pressed_d     = pressed_q;
        press_stb_d   = 1'b0;
        release_stb_d = 1'b0;
        long_stb_d    = 1'b0;
        if (tick) begin
            // The hold time keeps running through a release glitch.
            if ((state_q == ST_HELD || state_q == ST_REL_PEND) && hold_q < HOLD_MAX) begin
                hold_d     = hold_q + 1'b1;
                long_stb_d = ((hold_q + 1'b1) == HOLD_MAX);
            end
            case (state_q)
                ST_IDLE: begin
                    if (sample) begin
                        state_d = ST_PRESS_PEND;
                        db_d    = DB_W'(1);
                    end
                end
                ST_PRESS_PEND: begin
                    if (!sample) begin
                        state_d = ST_IDLE;
                        db_d    = '0;
                    end else if (db_inc >= DB_LIMIT) begin
                        state_d     = ST_HELD;
                        db_d        = '0;
                        hold_d      = '0;
                        pressed_d   = 1'b1;
                        press_stb_d = 1'b1;
                    end else begin
                        db_d = db_inc[DB_W-1:0];
                    end
                end
                ST_HELD: begin
                    if (!sample) begin
                        state_d = ST_REL_PEND;
                        db_d    = DB_W'(1);
                    end
                end
                ST_REL_PEND: begin
                    if (sample) begin
                        state_d = ST_HELD;
                        db_d    = '0;
                    end else if (db_inc >= DB_LIMIT) begin
                        state_d       = ST_IDLE;
                        db_d          = '0;
                        hold_d        = '0;
                        pressed_d     = 1'b0;
                        release_stb_d = 1'b1;
                        long_stb_d    = 1'b0;
                    end else begin
                        db_d = db_inc[DB_W-1:0];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    db_d    = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            db_q          <= '0;
            hold_q        <= '0;
            pressed_q     <= 1'b0;
            press_stb_q   <= 1'b0;
            release_stb_q <= 1'b0;
            long_stb_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            db_q          <= db_d;
            hold_q        <= hold_d;
            pressed_q     <= pressed_d;
            press_stb_q   <= press_stb_d;
            release_stb_q <= release_stb_d;
            long_stb_q    <= long_stb_d;
        end
    end

    assign pressed     = pressed_q;
    assign press_stb   = press_stb_q;
    assign release_stb = release_stb_q;
    assign long_stb    = long_stb_q;

endmodule

// File: rtl/btn_reader.sv
// Multi-button reader: one shared sample-tick prescaler feeding an
// independent debounce/long-press channel per button.
module btn_reader
    import btn_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int CLK_HZ         = 100000000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] pressed,
    output logic [NUM_BTN-1:0] press_stb,
    output logic [NUM_BTN-1:0] release_stb,
    output logic [NUM_BTN-1:0] long_stb,
    output logic               tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = cnt_width(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;

    always_comb begin
        pre_d  = pre_q + 1'b1;
        tick_d = 1'b0;
        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .LONG_TICKS     (LONG_TICKS),
                .ACTIVE_LOW     (ACTIVE_LOW)
            ) u_btn (
                .clk         (clk),
                .rst_n       (rst_n),
                .tick        (tick_q),
                .btn         (btn[gi]),
                .pressed     (pressed[gi]),
                .press_stb   (press_stb[gi]),
                .release_stb (release_stb[gi]),
                .long_stb    (long_stb[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_reader.sv
// Scoreboard bench for btn_reader: stimulus queues expected strobe events,
// a monitor pops and compares them whenever a strobe appears.
module tb_btn_reader;

    localparam int NB = 2;
    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2;

    typedef struct {
        int cyc;
        int kind;
        int bit_idx;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic [NB-1:0] pressed, press_stb, release_stb, long_stb;
    logic          tick;

    int  cyc;
    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];

    btn_reader #(
        .NUM_BTN        (NB),
        .CLK_HZ         (100),
        .TICK_HZ        (10),
        .DEBOUNCE_TICKS (3),
        .LONG_TICKS     (8),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .pressed     (pressed),
        .press_stb   (press_stb),
        .release_stb (release_stb),
        .long_stb    (long_stb),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic string kname(input int k);
        case (k)
            K_PRESS: return "press";
            K_REL:   return "release";
            default: return "long";
        endcase
    endfunction

    function automatic logic stb_bit(input int k, input int i);
        case (k)
            K_PRESS: return press_stb[i];
            K_REL:   return release_stb[i];
            default: return long_stb[i];
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s value=%0d (cyc=%0d)", name, act, cyc);
        end
    endtask

    task automatic push(input int c, input int k, input int b);
        ev_t e;
        e.cyc = c; e.kind = k; e.bit_idx = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: strobe scoreboard plus the free-running tick period.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_%s[%0d] actual=none required_cyc=%0d (cyc=%0d)",
                         kname(exp_q[0].kind), exp_q[0].bit_idx, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            for (int i = 0; i < NB; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (stb_bit(k, i)) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_%s[%0d] actual=pulse required=none (cyc=%0d)",
                                     kname(k), i, cyc);
                        end else begin
                            ev_t e;
                            e = exp_q.pop_front();
                            checks++;
                            if (e.kind != k || e.bit_idx != i || e.cyc != cyc) begin
                                failures++;
                                $display("FAIL strobe actual=%s[%0d]@%0d required=%s[%0d]@%0d",
                                         kname(k), i, cyc, kname(e.kind), e.bit_idx, e.cyc);
                            end else begin
                                $display("ok   strobe %s[%0d] at cyc=%0d", kname(k), i, cyc);
                            end
                        end
                    end
                end
            end
            checks++;
            if (tick !== ((cyc != 0) && (cyc % 10 == 0))) begin
                failures++;
                $display("FAIL tick actual=%0b required=%0b (cyc=%0d)", tick,
                         ((cyc != 0) && (cyc % 10 == 0)), cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        btn   = 2'b11;
        repeat (3) @(negedge clk);
        check("reset_pressed", int'(pressed), 0);
        check("reset_strobes", int'({press_stb, release_stb, long_stb}), 0);
        check("reset_tick", int'(tick), 0);
        rst_n = 1'b1;

        // Idle period: only ticks may toggle.
        wait_cyc(50);  check("idle_pressed_50", int'(pressed), 0);
        wait_cyc(100); check("idle_pressed_100", int'(pressed), 0);

        // Simple press, held 50 cycles, then release.
        wait_cyc(105); btn[0] = 1'b0; push(131, K_PRESS, 0);
        wait_cyc(150); check("a_pressed_held", int'(pressed), 1);
        wait_cyc(155); btn[0] = 1'b1; push(181, K_REL, 0);
        wait_cyc(185); check("a_pressed_released", int'(pressed), 0);

        // Bounce: two-tick presses never confirm.
        for (int r = 0; r < 3; r++) begin
            wait_cyc(205 + 40 * r); btn[0] = 1'b0;
            wait_cyc(225 + 40 * r); btn[0] = 1'b1;
        end
        wait_cyc(320); check("b_bounce_pressed", int'(pressed), 0);

        // Long press: LONG 8 ticks after PRESS, RELEASE 3 ticks after release.
        wait_cyc(405); btn[0] = 1'b0; push(431, K_PRESS, 0); push(511, K_LONG, 0);
        wait_cyc(470); check("c_pressed_held", int'(pressed), 1);
        wait_cyc(545); btn[0] = 1'b1; push(571, K_REL, 0);
        wait_cyc(560); check("c_pressed_rel_pend", int'(pressed), 1);
        wait_cyc(575); check("c_pressed_released", int'(pressed), 0);

        // One-tick release glitch while held: no release, long timing intact.
        wait_cyc(605); btn[0] = 1'b0; push(631, K_PRESS, 0);
        wait_cyc(645); btn[0] = 1'b1;
        wait_cyc(655); btn[0] = 1'b0; push(711, K_LONG, 0);
        wait_cyc(680); check("d_pressed_after_glitch", int'(pressed), 1);
        wait_cyc(745); btn[0] = 1'b1; push(771, K_REL, 0);
        wait_cyc(780); check("d_pressed_released", int'(pressed), 0);

        // Both buttons together, then asynchronous reset mid-hold.
        wait_cyc(805); btn = 2'b00; push(831, K_PRESS, 0); push(831, K_PRESS, 1);
        wait_cyc(840); check("e_pressed_both", int'(pressed), 3);
        wait_cyc(855);
        #2 rst_n = 1'b0;
        #1;
        check("e_async_pressed", int'(pressed), 0);
        check("e_async_strobes", int'({press_stb, release_stb, long_stb}), 0);
        check("e_async_tick", int'(tick), 0);
        btn = 2'b11;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(40);
        check("e_post_reset_pressed", int'(pressed), 0);
        check("pending_events", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_reader.md
BTN_READER -- requirements
Module: btn_reader

Interface
REQ-001 Parameter NUM_BTN, default 4: number of independent button inputs.
REQ-002 Parameter CLK_HZ, default 100000000: CLK frequency.
REQ-003 Parameter TICK_HZ, default 1000: sample tick rate.
REQ-004 Parameter DEBOUNCE_TICKS, default 10: number of stable ticks that confirm a level change.
REQ-005 Parameter LONG_TICKS, default 1000: number of held ticks that qualify a long press.
REQ-006 Parameter ACTIVE_LOW, default 1: when 1, a raw input at 0 means pressed.
REQ-007 CLK  input  1  system clock, rising edge.
REQ-008 RST_N  input  1  reset, asynchronous, active-low.
REQ-009 BTN  input  NUM_BTN  raw asynchronous button pins.
REQ-010 PRESSED  output  NUM_BTN  debounced level, 1 means pressed.
REQ-011 PRESS_STB  output  NUM_BTN  one-cycle pulse on each confirmed press.
REQ-012 RELEASE_STB  output  NUM_BTN  one-cycle pulse on each confirmed release.
REQ-013 LONG_STB  output  NUM_BTN  one-cycle pulse when a hold reaches LONG_TICKS.
REQ-014 TICK  output  1  sample strobe, exported as a test signal.

Function
REQ-015 The prescaler SHALL count 0..CLK_HZ/TICK_HZ-1, wrap to 0, and assert TICK for exactly the one cycle in which the count wraps.
REQ-016 Each BTN bit SHALL pass through a two-flop synchronizer, then be normalised to a "pressed" sense using ACTIVE_LOW.
REQ-017 Each button SHALL run an independent FSM with states IDLE, PRESS_PEND, HELD and REL_PEND; the FSM advances only in cycles where TICK=1.
REQ-018 IDLE: a pressed sample SHALL move to PRESS_PEND with the debounce count set to 1; otherwise the FSM stays in IDLE.
REQ-019 PRESS_PEND: a released sample SHALL return to IDLE with the count cleared; a pressed sample increments the count, and reaching DEBOUNCE_TICKS moves to HELD, sets PRESSED, and pulses PRESS_STB.
REQ-020 HELD: the hold counter SHALL increment on each tick and saturate at LONG_TICKS; LONG_STB pulses once, on the tick at which the counter first equals LONG_TICKS; a released sample moves to REL_PEND with the debounce count set to 1.
REQ-021 REL_PEND: a pressed sample SHALL return to HELD; the hold counter is preserved and no strobe is issued. A released sample increments the count, and reaching DEBOUNCE_TICKS moves to IDLE, clears PRESSED, pulses RELEASE_STB, and clears the hold counter.
REQ-022 All outputs SHALL be registered; each strobe SHALL be high for exactly the one cycle after the TICK cycle that caused the transition.
REQ-023 Worst-case press latency from a raw edge SHALL be 2 cycles (synchronizer) plus DEBOUNCE_TICKS ticks plus 1 cycle.
REQ-024 If DEBOUNCE_TICKS is 1, the FSM SHALL pass through the pend state in a single tick; the count SHALL compare with >= so that it cannot overrun.
REQ-025 Simultaneous events on different buttons SHALL produce independent, simultaneous strobes.
REQ-026 Counter widths SHALL be the clog2 of (bound+1); no counter may wrap.

Reset
REQ-027 While RST_N=0: the prescaler, all counters and all strobes are 0; TICK=0; PRESSED=0; every FSM is in IDLE; the synchronizer flops hold the inactive level.
REQ-028 Reset asserted mid-hold SHALL clear state immediately with no RELEASE_STB; after deassertion, the first tick occurs CLK_HZ/TICK_HZ cycles later.

Structure
REQ-029 The FSM state encoding and the counter-width helper SHALL live in the shared package btn_pkg.
REQ-030 The per-button synchronizer and FSM SHALL be the sub-module btn_debounce, instantiated NUM_BTN times; the prescaler is shared in btn_reader.

Verification (CLK_HZ=100, TICK_HZ=10, DEBOUNCE_TICKS=3, LONG_TICKS=8, NUM_BTN=2)
REQ-031 Reset then idle for 100 cycles -> TICK pulses every 10 cycles; all other outputs stay 0.
REQ-032 Press BTN[0] (drive it to 0) and hold it for 50 cycles -> PRESS_STB[0] pulses once, within 3-4 ticks; PRESSED[0]=1; BTN[1] outputs are unaffected.
REQ-033 Bounce the input with a 2-tick press then release, repeated -> no strobes at all and PRESSED stays 0.
REQ-034 Hold the button for 100 cycles, then release -> exactly one LONG_STB 8 ticks after PRESS_STB; RELEASE_STB 3 ticks after the release; PRESSED falls with it.
REQ-035 While in HELD, a 1-tick release glitch -> no RELEASE_STB, and the long-press timing is unchanged.
REQ-036 Press both buttons in the same cycle -> PRESS_STB[0] and PRESS_STB[1] pulse in the same cycle; RST_N pulled low mid-hold -> all outputs are 0 asynchronously, with no strobe.
